// File: rtl/fetch_stage.sv
// fetch_stage: PC owner that assembles one/two-word instructions with stall, branch redirect and optional halt (FETCH_HALT_EN)
module fetch_stage #(
  parameter int PC_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
`ifdef FETCH_HALT_EN
  , parameter logic [4:0] HALT_OPCODE = 5'b11111
`endif
) (
  input  logic                clk,
  input  logic                rst,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic [15:0]         imem_data,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  output logic                valid_out,
  output logic [4:0]          opcode,
  output logic [2:0]          dst_addr,
  output logic [2:0]          src_addr,
  output logic                category,
  output logic [15:0]         immediate,
  output logic [PC_WIDTH-1:0] pc_out
);
  typedef enum logic [1:0] {S_OP, S_IMM, S_HALT} state_t;
  state_t r_state, w_state;
  logic [PC_WIDTH-1:0] r_pc, w_pc, r_hold_pc, w_hold_pc, w_pc_out;
  logic [10:0] r_hold, w_hold, w_fields;
  logic w_valid, w_cat, w_unused;
  logic [15:0] w_imm;
  assign imem_addr = r_pc;
  assign w_unused = ^imem_data[3:0];
  always_comb begin
    w_state = r_state;
    w_pc = r_pc;
    w_hold = r_hold;
    w_hold_pc = r_hold_pc;
    w_valid = valid_out;
    w_fields = {opcode, dst_addr, src_addr};
    w_cat = category;
    w_imm = immediate;
    w_pc_out = pc_out;
    if (branch_taken) begin
      w_state = S_OP;
      w_pc = branch_target;
      w_valid = 1'b0;
      w_hold = '0;
      w_hold_pc = '0;
    end else if (r_state == S_HALT) begin
      w_valid = 1'b0;
    end else if (!stall) begin
      w_pc = r_pc + PC_WIDTH'(1);
      if (r_state == S_IMM) begin
        w_state = S_OP;
        w_valid = 1'b1;
        w_fields = r_hold;
        w_cat = 1'b1;
        w_imm = imem_data;
        w_pc_out = r_hold_pc;
      end else if (imem_data[4]) begin
        w_state = S_IMM;
        w_valid = 1'b0;
        w_hold = imem_data[15:5];
        w_hold_pc = r_pc;
      end else begin
        w_valid = 1'b1;
        w_fields = imem_data[15:5];
        w_cat = 1'b0;
        w_imm = '0;
        w_pc_out = r_pc;
`ifdef FETCH_HALT_EN
        if (imem_data[15:11] == HALT_OPCODE) w_state = S_HALT;
`endif
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_OP;
      r_pc <= RESET_PC;
      r_hold <= '0;
      r_hold_pc <= '0;
      valid_out <= 1'b0;
      {opcode, dst_addr, src_addr} <= '0;
      category <= 1'b0;
      immediate <= '0;
      pc_out <= '0;
    end else begin
      r_state <= w_state;
      r_pc <= w_pc;
      r_hold <= w_hold;
      r_hold_pc <= w_hold_pc;
      valid_out <= w_valid;
      {opcode, dst_addr, src_addr} <= w_fields;
      category <= w_cat;
      immediate <= w_imm;
      pc_out <= w_pc_out;
    end
  end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the decoding stage.
- Owns the PC, reads 16-bit words from instruction memory, and assembles one- or two-word instructions.
- Registers src_addr, dst_addr, category, immediate and opcode for the decoder.
- Handles stall, branch redirect and an optional halt.

Parameters:
- PC_WIDTH, 16, width of PC and instruction-memory address.
- RESET_PC, 16'h0000, PC value loaded on reset.
- HALT_OPCODE, 5'b11111, opcode recognised as halt (used only with FETCH_HALT_EN).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_addr  output  PC_WIDTH  instruction memory address; equals current PC, combinational from PC register.
- imem_data  input  16  instruction word at imem_addr, valid same cycle (asynchronous-read memory).
- stall  input  1  hold PC, FSM and all output registers.
- branch_taken  input  1  redirect request.
- branch_target  input  PC_WIDTH  new PC when branch_taken=1.
- valid_out  output  1  output fields hold a complete instruction.
- opcode  output  5  instr[15:11].
- dst_addr  output  3  instr[10:8].
- src_addr  output  3  instr[7:5].
- category  output  1  1 = instruction carries an immediate (drives the decoder's second-operand mux select).
- immediate  output  16  second word of a two-word instruction, else 16'h0000.
- pc_out  output  PC_WIDTH  address of the first word of the instruction on the outputs.

Behaviour:
- Instruction format: [15:11] opcode, [10:8] dst, [7:5] src, [4] has_imm, [3:0] ignored. has_imm=1 means the next word is the immediate.
- Reset (synchronous, active-high, highest priority):
  - PC=RESET_PC, state=OP.
  - valid_out=0; opcode, dst_addr, src_addr, category, immediate, pc_out all 0.
  - Holding registers cleared.
- Priority each cycle: rst > branch_taken > stall > normal.
- FSM states: OP (expect opcode word), IMM (expect immediate word).
- OP, normal cycle:
  - has_imm=0: outputs load fields from imem_data; category=0, immediate=0, pc_out=PC, valid_out=1. PC+=1, stay OP.
  - has_imm=1: fields and PC go to holding registers; valid_out=0 next cycle; PC+=1; go to IMM.
- IMM, normal cycle:
  - Outputs load the held fields; immediate=imem_data, category=1, pc_out=held PC, valid_out=1.
  - PC+=1, go to OP.
- Latency: a one-word instruction is on the outputs 1 cycle after its address is presented. A two-word instruction appears after 2 cycles, with one bubble (valid_out=0) between.
- stall=1: PC, state, holding and output registers all unchanged, including valid_out. imem_data is ignored.
- branch_taken=1 (stall ignored):
  - PC=branch_target, state=OP, valid_out=0.
  - Holding registers discarded, so a half-fetched two-word instruction is aborted.
  - Other output fields may hold stale values but must be ignored while valid_out=0.
- PC arithmetic is modulo 2^PC_WIDTH; FFFF+1 wraps to 0000.
  - A two-word instruction whose opcode sits at FFFF takes its immediate from 0000.
- rst asserted mid two-word fetch: same as reset; no partial instruction emitted.

Optional Feature:
- Macro: FETCH_HALT_EN.
- Defined:
  - A one-word instruction with opcode==HALT_OPCODE is emitted normally (valid_out=1 for one cycle).
  - The stage then enters HALTED: PC frozen at the halt address+1, valid_out=0 every cycle.
  - Leaves HALTED only on rst or branch_taken; branch behaves as above.
  - stall has no effect in HALTED.
- Not defined: no HALTED state; HALT_OPCODE is an ordinary opcode and fetch continues.

Test Plan:
- Reset then sequential fetch:
  - Stimulus: memory [0]=16'h1A40 (op 3, dst 2, src 2, no imm), [1]=16'h2320.
  - Response: cycle 1 after reset release: valid_out=1, opcode=3, dst=2, src=2, category=0, pc_out=0. Cycle 2: opcode=4, dst=3, src=1, pc_out=1.
- Two-word instruction:
  - Stimulus: [0]=16'h0A30 (has_imm), [1]=16'hBEEF.
  - Response: cycle 1 valid_out=0; cycle 2 valid_out=1, category=1, immediate=16'hBEEF, dst=2, src=1, pc_out=0; PC=2.
- Stall:
  - Stimulus: assert stall 3 cycles mid-stream.
  - Response: imem_addr and all outputs constant for 3 cycles; sequence resumes with no instruction lost or duplicated.
- Branch aborting an immediate fetch:
  - Stimulus: branch_taken=1, target=16'h0040, in the IMM cycle of a two-word instruction (stall=1 same cycle).
  - Response: next cycle valid_out=0, imem_addr=16'h0040; the aborted instruction is never emitted.
- Wrap-around:
  - Stimulus: branch to 16'hFFFF holding a has_imm opcode, [0000]=16'h1234.
  - Response: immediate=16'h1234, pc_out=16'hFFFF; PC next=0001.
- Halt (FETCH_HALT_EN defined):
  - Stimulus: fetch 16'hF800.
  - Response: one valid cycle with opcode=5'b11111, then valid_out=0 and imem_addr constant; after branch_taken, fetch resumes at the target.
